spike_rate_decoder: RTL and testbench

Converts a binary spike train, such as the spike output of the LIF neuron, back into numeric values. This is the decode direction of the neuron's rate coding.
- Rate path: counts spikes over a programmable window of clock cycles and reports the count with a one-cycle valid strobe.
- ISI path: independently measures the inter-spike interval (ISI) in cycles.
- Sits downstream of neuron spike outputs and feeds readout logic or output pins.

---
 rtl/spike_rate_decoder.sv | 119 +++++++++++
 tb/tb_spike_rate_decoder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_decoder.sv
// Decodes a spike train back into numbers: spike count per programmable window
// (rate path) and cycles between consecutive spikes (ISI path).
//
// state | meaning
// IDLE  | no window open; waits for ena with a non-zero window_len
// COUNT | counting spikes; remaining holds sample edges left in the window
module spike_rate_decoder #(
  parameter int WINDOW_W = 8,
  parameter int COUNT_W  = 6,
  parameter int ISI_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                spike_in,
  input  logic [WINDOW_W-1:0] window_len,
  output logic [COUNT_W-1:0]  rate_out,
  output logic                rate_sat,
  output logic                rate_valid,
  output logic [ISI_W-1:0]    isi_out,
  output logic                isi_valid,
  output logic                busy
);

  typedef enum logic {IDLE, COUNT} state_t;

  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};
  localparam logic [ISI_W-1:0]   ICNT_MAX  = {ISI_W{1'b1}};

  state_t              state;
  logic [WINDOW_W-1:0] remaining;
  logic [COUNT_W-1:0]  count;
  logic                sat;
  logic [ISI_W-1:0]    icnt;
  logic                seen_first;

  logic [COUNT_W-1:0]  count_nxt;
  logic                sat_nxt;

  // Count including the current sample; needed both mid-window and on the final edge.
  always_comb begin
    count_nxt = count;
    sat_nxt   = sat;
    if (spike_in) begin
      if (count == COUNT_MAX) sat_nxt = 1'b1;
      else                    count_nxt = count + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      remaining  <= '0;
      count      <= '0;
      sat        <= 1'b0;
      rate_out   <= '0;
      rate_sat   <= 1'b0;
      rate_valid <= 1'b0;
    end else begin
      rate_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ena && window_len != '0) begin
            remaining <= window_len;
            count     <= '0;
            sat       <= 1'b0;
            state     <= COUNT;
          end
        end
        COUNT: begin
          if (!ena) begin
            state <= IDLE;
          end else if (remaining == WINDOW_W'(1)) begin
            rate_out   <= count_nxt;
            rate_sat   <= sat_nxt;
            rate_valid <= 1'b1;
            count      <= '0;
            sat        <= 1'b0;
            // Reload on the same edge so consecutive windows leave no gap.
            if (window_len != '0) remaining <= window_len;
            else                  state     <= IDLE;
          end else begin
            count     <= count_nxt;
            sat       <= sat_nxt;
            remaining <= remaining - WINDOW_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icnt       <= '0;
      seen_first <= 1'b0;
      isi_out    <= '0;
      isi_valid  <= 1'b0;
    end else begin
      isi_valid <= 1'b0;
      if (!ena) begin
        icnt       <= '0;
        seen_first <= 1'b0;
      end else if (spike_in) begin
        if (seen_first) begin
          isi_out   <= icnt;
          isi_valid <= 1'b1;
        end
        icnt       <= ISI_W'(1);
        seen_first <= 1'b1;
      end else if (icnt != ICNT_MAX) begin
        icnt <= icnt + ISI_W'(1);
      end
    end
  end

  assign busy = (state == COUNT);

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed-vector bench for spike_rate_decoder with hand-computed expectations.
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       spike_in;
  logic [7:0] window_len;
  logic [5:0] rate_out;
  logic       rate_sat;
  logic       rate_valid;
  logic [7:0] isi_out;
  logic       isi_valid;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  int pulses;

  spike_rate_decoder #(.WINDOW_W(8), .COUNT_W(6), .ISI_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .spike_in   (spike_in),
    .window_len (window_len),
    .rate_out   (rate_out),
    .rate_sat   (rate_sat),
    .rate_valid (rate_valid),
    .isi_out    (isi_out),
    .isi_valid  (isi_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; spike_in = 1'b0; window_len = 8'd0;
    #12;
    check("rst_rate_out", rate_out, 0);
    check("rst_rate_valid", rate_valid, 0);
    check("rst_isi_out", isi_out, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();

    // Window of 10, spikes on odd samples; spike on the start edge must be ignored.
    window_len = 8'd10; ena = 1'b1; spike_in = 1'b1;
    step();
    check("start_busy", busy, 1);
    pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      spike_in = (i % 2 == 1);
      step();
      if (i < 10) pulses += rate_valid;
    end
    check("alt_early_pulse", pulses, 0);
    check("alt_valid", rate_valid, 1);
    check("alt_rate", rate_out, 5);
    check("alt_sat", rate_sat, 0);
    spike_in = 1'b0;
    step();
    check("alt_valid_single", rate_valid, 0);

    // Back-to-back windows with spikes straddling the boundary.
    ena = 1'b0; step();
    ena = 1'b1; step();
    pulses = 0;
    for (int s = 1; s <= 20; s++) begin
      spike_in = (s == 10 || s == 11);
      step();
      pulses += rate_valid;
      if (s == 10) begin
        check("b2b_w1_valid", rate_valid, 1);
        check("b2b_w1_rate", rate_out, 1);
        check("b2b_busy", busy, 1);
      end
      if (s == 20) begin
        check("b2b_w2_valid", rate_valid, 1);
        check("b2b_w2_rate", rate_out, 1);
      end
    end
    check("b2b_pulses", pulses, 2);

    // Saturation: 100 spikes into a 6-bit counter; mid-window length change ignored.
    ena = 1'b0; step();
    window_len = 8'd100; ena = 1'b1; spike_in = 1'b0; step();
    window_len = 8'd7; spike_in = 1'b1;
    pulses = 0;
    for (int s = 1; s <= 99; s++) begin
      step();
      pulses += rate_valid;
    end
    check("sat_early_pulse", pulses, 0);
    step();
    check("sat_valid", rate_valid, 1);
    check("sat_rate", rate_out, 63);
    check("sat_flag", rate_sat, 1);

    // Single-sample window.
    ena = 1'b0; spike_in = 1'b0; step();
    window_len = 8'd1; ena = 1'b1; step();
    spike_in = 1'b1; step();
    check("len1_valid", rate_valid, 1);
    check("len1_rate", rate_out, 1);
    check("len1_sat", rate_sat, 0);

    // ISI: spikes on enabled edges 3, 7, 8, then a long gap.
    ena = 1'b0; spike_in = 1'b0; window_len = 8'd0; step();
    ena = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      spike_in = (e == 3 || e == 7 || e == 8);
      step();
      if (e == 3) check("isi_first_none", isi_valid, 0);
      if (e == 7) begin
        check("isi_e7_valid", isi_valid, 1);
        check("isi_e7_val", isi_out, 4);
      end
      if (e == 8) begin
        check("isi_e8_valid", isi_valid, 1);
        check("isi_e8_val", isi_out, 1);
      end
    end
    spike_in = 1'b0;
    repeat (300) step();
    spike_in = 1'b1; step();
    check("isi_sat_valid", isi_valid, 1);
    check("isi_sat_val", isi_out, 255);
    check("isi_rate_held", rate_out, 1);

    // ena dropped at sample 4 of a 10-cycle window.
    ena = 1'b0; spike_in = 1'b0; step();
    window_len = 8'd10; ena = 1'b1; step();
    for (int s = 1; s <= 3; s++) begin
      spike_in = (s == 2);
      step();
    end
    ena = 1'b0; spike_in = 1'b0; step();
    check("abort_busy", busy, 0);
    check("abort_valid", rate_valid, 0);
    pulses = 0;
    repeat (12) begin
      step();
      pulses += rate_valid;
    end
    check("abort_no_pulse", pulses, 0);
    check("abort_rate_held", rate_out, 1);
    ena = 1'b1; window_len = 8'd0; spike_in = 1'b1; step();
    check("abort_isi_none", isi_valid, 0);
    spike_in = 1'b0; step();
    spike_in = 1'b1; step();
    check("abort_isi_valid", isi_valid, 1);
    check("abort_isi_val", isi_out, 2);

    // Asynchronous reset at window cycle 5.
    ena = 1'b0; spike_in = 1'b0; step();
    window_len = 8'd10; ena = 1'b1; step();
    spike_in = 1'b1;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_rate_out", rate_out, 0);
    check("mrst_isi_out", isi_out, 0);
    ena = 1'b0; spike_in = 1'b0;
    step();
    rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      step();
      pulses += rate_valid + busy;
    end
    check("mrst_idle_after", pulses, 0);
    ena = 1'b1; step();
    check("mrst_restart_busy", busy, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
